// File: rtl/chooser_update_scheduler_pkg.sv
// Shared definitions for the chooser update scheduler.
// Holds the default parameter values, the scheduler state encoding and the
// saturating counter helpers used when an update is enqueued.
package chooser_update_scheduler_pkg;

   localparam int unsigned DefWidthCounter = 2;
   localparam int unsigned DefIndexBits    = 14;
   localparam int unsigned DefFifoDepth    = 4;
   localparam int unsigned DefInitValue    = 3;

   typedef enum logic {
      StInit,
      StRun
   } state_e;

   // Increment, holding at the largest value representable in 'width' bits.
   function automatic int unsigned sat_inc(int unsigned v, int unsigned width);
      int unsigned max_v;
      max_v = (32'd1 << width) - 32'd1;
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

   // Decrement, holding at zero.
   function automatic int unsigned sat_dec(int unsigned v);
      return (v == 32'd0) ? 32'd0 : v - 32'd1;
   endfunction

endpackage

// File: rtl/chooser_update_scheduler_if.sv
// Bus bundle between the chooser update scheduler and its neighbours.
//   pred_*    : prediction-side read request / ready
//   chooser_* : counter returned one cycle after an accepted read
//   upd_*     : resolved-branch update request / ready
//   mem_*     : single-port chooser table (one-cycle read latency)
// The slave modport is the scheduler's view; master is the environment's.
interface chooser_update_scheduler_if
   import chooser_update_scheduler_pkg::*;
#(
   parameter int unsigned WIDTH_COUNTER = DefWidthCounter,
   parameter int unsigned INDEX_BITS    = DefIndexBits
);
   logic                     pred_valid;
   logic [INDEX_BITS-1:0]    pred_index;
   logic                     pred_ready;
   logic                     chooser_valid;
   logic [WIDTH_COUNTER-1:0] chooser_out;
   logic                     upd_valid;
   logic [INDEX_BITS-1:0]    upd_index;
   logic [WIDTH_COUNTER-1:0] upd_counter;
   logic                     upd_dir;
   logic                     upd_batage;
   logic                     upd_bfnp;
   logic                     upd_ready;
   logic                     mem_en;
   logic                     mem_we;
   logic [INDEX_BITS-1:0]    mem_addr;
   logic [WIDTH_COUNTER-1:0] mem_wdata;
   logic [WIDTH_COUNTER-1:0] mem_rdata;

   modport slave (
      input  pred_valid, pred_index, upd_valid, upd_index, upd_counter,
      input  upd_dir, upd_batage, upd_bfnp, mem_rdata,
      output pred_ready, chooser_valid, chooser_out, upd_ready,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output pred_valid, pred_index, upd_valid, upd_index, upd_counter,
      output upd_dir, upd_batage, upd_bfnp, mem_rdata,
      input  pred_ready, chooser_valid, chooser_out, upd_ready,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/chooser_update_fifo.sv
// Pending-update queue with a bypass search.
//   push_*  : enqueue an (index, value) pair
//   pop_i   : drop the head entry (head_* shows it)
//   flush_i : clear count and pointers; wins over a same-cycle push
//   lookup_idx_i / hit_* : youngest stored entry matching the index.
// The search only sees registered contents, so a same-cycle push is never
// returned. Depth must be a power of two, at least 2.
module chooser_update_fifo
   import chooser_update_scheduler_pkg::*;
#(
   parameter int unsigned Depth        = DefFifoDepth,
   parameter int unsigned IndexBits    = DefIndexBits,
   parameter int unsigned WidthCounter = DefWidthCounter
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush_i,
   input  logic                    push_i,
   input  logic [IndexBits-1:0]    push_idx_i,
   input  logic [WidthCounter-1:0] push_val_i,
   input  logic                    pop_i,
   output logic [IndexBits-1:0]    head_idx_o,
   output logic [WidthCounter-1:0] head_val_o,
   output logic                    full_o,
   output logic                    empty_o,
   input  logic [IndexBits-1:0]    lookup_idx_i,
   output logic                    hit_o,
   output logic [WidthCounter-1:0] hit_val_o
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [IndexBits-1:0]    idx_q [Depth];
   logic [WidthCounter-1:0] val_q [Depth];
   logic [PtrW-1:0]         rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]         count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) begin
         idx_q[wr_ptr_q] <= push_idx_i;
         val_q[wr_ptr_q] <= push_val_i;
      end
   end

   assign head_idx_o = idx_q[rd_ptr_q];
   assign head_val_o = val_q[rd_ptr_q];
   assign full_o     = (count_q == CntW'(Depth));
   assign empty_o    = (count_q == '0);

   // Walk oldest to youngest; the last match overwrites, so youngest wins.
   always_comb begin
      hit_o     = 1'b0;
      hit_val_o = '0;
      for (int unsigned k = 0; k < Depth; k++) begin
         if ((CntW'(k) < count_q) && (idx_q[rd_ptr_q + PtrW'(k)] == lookup_idx_i)) begin
            hit_o     = 1'b1;
            hit_val_o = val_q[rd_ptr_q + PtrW'(k)];
         end
      end
   end

endmodule

// File: rtl/chooser_update_scheduler.sv
// Chooser table port scheduler.
// After reset the table is swept with INIT_VALUE (INIT), then the single
// table port is shared between prediction reads and queued counter writes
// (RUN). Updates whose counter would not change are accepted and dropped.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : discard all queued updates
//   busy_o     : high while sweeping or while updates are pending
//   bus_io     : prediction, update and table-port signals (slave view)
module chooser_update_scheduler
   import chooser_update_scheduler_pkg::*;
#(
   parameter int unsigned WIDTH_COUNTER = DefWidthCounter,
   parameter int unsigned INDEX_BITS    = DefIndexBits,
   parameter int unsigned FIFO_DEPTH    = DefFifoDepth,
   parameter int unsigned INIT_VALUE    = DefInitValue
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush_i,
   output logic                      busy_o,
   chooser_update_scheduler_if.slave bus_io
);
   state_e                   state_q, state_d;
   logic [INDEX_BITS-1:0]    ptr_q, ptr_d;
   logic                     cv_q;
   logic                     byp_hit_q;
   logic [WIDTH_COUNTER-1:0] byp_val_q;

   logic                     mem_en, mem_we;
   logic [INDEX_BITS-1:0]    mem_addr;
   logic [WIDTH_COUNTER-1:0] mem_wdata;
   logic                     pred_ready, upd_ready, rd_acc, pop, push;
   logic [WIDTH_COUNTER-1:0] upd_new;
   logic [INDEX_BITS-1:0]    head_idx;
   logic [WIDTH_COUNTER-1:0] head_val;
   logic                     fifo_full, fifo_empty, byp_hit;
   logic [WIDTH_COUNTER-1:0] byp_val;

   // Counter moves toward whichever sub-predictor was right when they disagree.
   always_comb begin
      upd_new = bus_io.upd_counter;
      if (bus_io.upd_batage != bus_io.upd_bfnp) begin
         if (bus_io.upd_dir == bus_io.upd_bfnp) begin
            upd_new = WIDTH_COUNTER'(sat_inc(32'(bus_io.upd_counter), WIDTH_COUNTER));
         end else begin
            upd_new = WIDTH_COUNTER'(sat_dec(32'(bus_io.upd_counter)));
         end
      end
   end

   assign push = bus_io.upd_valid && upd_ready && (upd_new != bus_io.upd_counter);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = ptr_q;
      mem_wdata  = head_val;
      pred_ready = 1'b0;
      upd_ready  = 1'b0;
      rd_acc     = 1'b0;
      pop        = 1'b0;
      case (state_q)
         StInit: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = WIDTH_COUNTER'(INIT_VALUE);
            ptr_d     = ptr_q + INDEX_BITS'(1);
            if (ptr_q == '1) state_d = StRun;
         end
         StRun: begin
            pred_ready = !fifo_full;
            upd_ready  = !fifo_full;
            // A full queue must drain before reads; otherwise reads go first.
            if (fifo_full || (!bus_io.pred_valid && !fifo_empty)) begin
               mem_en   = 1'b1;
               mem_we   = 1'b1;
               mem_addr = head_idx;
               pop      = 1'b1;
            end else if (bus_io.pred_valid) begin
               mem_en   = 1'b1;
               mem_addr = bus_io.pred_index;
               rd_acc   = 1'b1;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StInit;
         ptr_q     <= '0;
         cv_q      <= 1'b0;
         byp_hit_q <= 1'b0;
         byp_val_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cv_q      <= rd_acc;
         byp_hit_q <= rd_acc && byp_hit;
         byp_val_q <= byp_val;
      end
   end

   chooser_update_fifo #(
      .Depth        (FIFO_DEPTH),
      .IndexBits    (INDEX_BITS),
      .WidthCounter (WIDTH_COUNTER)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush_i),
      .push_i       (push),
      .push_idx_i   (bus_io.upd_index),
      .push_val_i   (upd_new),
      .pop_i        (pop),
      .head_idx_o   (head_idx),
      .head_val_o   (head_val),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .lookup_idx_i (bus_io.pred_index),
      .hit_o        (byp_hit),
      .hit_val_o    (byp_val)
   );

   // The sweep state would otherwise drive the port while reset is held.
   assign bus_io.mem_en        = mem_en & rst_n;
   assign bus_io.mem_we        = mem_we & rst_n;
   assign bus_io.mem_addr      = mem_addr;
   assign bus_io.mem_wdata     = mem_wdata;
   assign bus_io.pred_ready    = pred_ready;
   assign bus_io.upd_ready     = upd_ready;
   assign bus_io.chooser_valid = cv_q;
   assign bus_io.chooser_out   = !cv_q ? '0 : (byp_hit_q ? byp_val_q : bus_io.mem_rdata);
   assign busy_o               = (state_q == StInit) || !fifo_empty;

endmodule

// File: tb/tb_chooser_update_scheduler.sv
module tb_chooser_update_scheduler;
   localparam int unsigned W     = 2;
   localparam int unsigned IB    = 4;
   localparam int unsigned D     = 4;
   localparam int unsigned IV    = 3;
   localparam int          TSIZE = 16;
   localparam int          MAXC  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic busy;

   chooser_update_scheduler_if #(.WIDTH_COUNTER(W), .INDEX_BITS(IB)) bus ();

   chooser_update_scheduler #(
      .WIDTH_COUNTER (W),
      .INDEX_BITS    (IB),
      .FIFO_DEPTH    (D),
      .INIT_VALUE    (IV)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .busy_o  (busy),
      .bus_io  (bus)
   );

   always #5 clk = ~clk;

   // Table storage with one-cycle read latency.
   logic [W-1:0] tmem [TSIZE];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) tmem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata <= tmem[bus.mem_addr];
      end
   end

   // Reference model: pending updates as a queue, table as an int array.
   typedef struct { int idx; int val; } entry_t;
   entry_t mq[$];
   int ref_tab [TSIZE];
   bit m_init;
   int m_ptr;
   bit m_pv;
   int m_pval;

   bit e_en, e_we, e_pr, e_ur, e_busy, e_cv;
   int e_addr, e_wdata, e_co;
   int n_checks = 0;
   int n_pass = 0;

   function automatic int new_count(int c, bit d, bit b, bit f);
      if (b != f && d == f) return (c == MAXC) ? MAXC : c + 1;
      if (b != f && d == b) return (c == 0) ? 0 : c - 1;
      return c;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_init = 1'b1;
      m_ptr  = 0;
      m_pv   = 1'b0;
   endtask

   task automatic model_step(input bit pv, input int pidx, input bit uv, input int uidx,
                             input int ucnt, input bit udir, input bit ubat, input bit ubf,
                             input bit fl);
      int nv;
      bit full;
      entry_t e;
      e_cv    = m_pv;
      e_co    = m_pv ? m_pval : 0;
      m_pv    = 1'b0;
      e_en    = 1'b0;
      e_we    = 1'b0;
      e_addr  = 0;
      e_wdata = 0;
      if (m_init) begin
         e_en = 1'b1; e_we = 1'b1; e_addr = m_ptr; e_wdata = IV;
         e_pr = 1'b0; e_ur = 1'b0; e_busy = 1'b1;
         ref_tab[m_ptr] = IV;
         m_ptr++;
         if (m_ptr == TSIZE) begin
            m_init = 1'b0;
            m_ptr  = 0;
         end
      end else begin
         full   = (mq.size() == D);
         e_pr   = !full;
         e_ur   = !full;
         e_busy = (mq.size() != 0);
         if (full || (!pv && mq.size() != 0)) begin
            e_en = 1'b1; e_we = 1'b1; e_addr = mq[0].idx; e_wdata = mq[0].val;
            ref_tab[mq[0].idx] = mq[0].val;
            void'(mq.pop_front());
         end else if (pv) begin
            e_en   = 1'b1;
            e_addr = pidx;
            m_pv   = 1'b1;
            m_pval = ref_tab[pidx];
            foreach (mq[i]) if (mq[i].idx == pidx) m_pval = mq[i].val;
         end
         if (uv && !full) begin
            nv = new_count(ucnt, udir, ubat, ubf);
            if (nv != ucnt && !fl) begin
               e.idx = uidx;
               e.val = nv;
               mq.push_back(e);
            end
         end
         if (fl) mq.delete();
      end
   endtask

   // One clock of stimulus; model expectations are ready on return.
   task automatic cyc(input bit pv, input int pidx, input bit uv, input int uidx, input int ucnt,
                      input bit udir, input bit ubat, input bit ubf, input bit fl);
      @(negedge clk);
      bus.pred_valid  = pv;
      bus.pred_index  = IB'(pidx);
      bus.upd_valid   = uv;
      bus.upd_index   = IB'(uidx);
      bus.upd_counter = W'(ucnt);
      bus.upd_dir     = udir;
      bus.upd_batage  = ubat;
      bus.upd_bfnp    = ubf;
      flush           = fl;
      #1;
      model_step(pv, pidx, uv, uidx, ucnt, udir, ubat, ubf, fl);
   endtask

   task automatic test_reset();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy: got %0b want 1", busy); else n_pass++;
      n_checks++; if (bus.pred_ready !== 1'b0) $display("FAIL rst_pred_ready: got %0b want 0", bus.pred_ready); else n_pass++;
      n_checks++; if (bus.upd_ready !== 1'b0) $display("FAIL rst_upd_ready: got %0b want 0", bus.upd_ready); else n_pass++;
      n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mem_en: got %0b want 0", bus.mem_en); else n_pass++;
      n_checks++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we: got %0b want 0", bus.mem_we); else n_pass++;
      n_checks++; if (bus.chooser_valid !== 1'b0) $display("FAIL rst_cv: got %0b want 0", bus.chooser_valid); else n_pass++;
      n_checks++; if (bus.chooser_out !== 2'd0) $display("FAIL rst_co: got %0d want 0", bus.chooser_out); else n_pass++;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_init();
      for (int i = 0; i < TSIZE; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
         n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) $display("FAIL init_we %0d: got en=%0b we=%0b want 1/1", i, bus.mem_en, bus.mem_we); else n_pass++;
         n_checks++; if (bus.mem_addr !== IB'(i)) $display("FAIL init_addr: got %0d want %0d", bus.mem_addr, i); else n_pass++;
         n_checks++; if (bus.mem_wdata !== W'(IV)) $display("FAIL init_data %0d: got %0d want 3", i, bus.mem_wdata); else n_pass++;
         n_checks++; if (bus.pred_ready !== 1'b0) $display("FAIL init_pred_ready %0d: got %0b want 0", i, bus.pred_ready); else n_pass++;
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.pred_ready !== 1'b1) $display("FAIL init_run_ready: got %0b want 1", bus.pred_ready); else n_pass++;
      n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL init_run_idle: got %0b want 0", bus.mem_en); else n_pass++;
   endtask

   task automatic test_update_write();
      cyc(0, 0, 1, 5, 1, 1, 0, 1, 0);
      n_checks++; if (bus.upd_ready !== 1'b1) $display("FAIL upd_ready: got %0b want 1", bus.upd_ready); else n_pass++;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) $display("FAIL upd_write_en: got en=%0b we=%0b want 1/1", bus.mem_en, bus.mem_we); else n_pass++;
      n_checks++; if (bus.mem_addr !== 4'd5) $display("FAIL upd_write_addr: got %0d want 5", bus.mem_addr); else n_pass++;
      n_checks++; if (bus.mem_wdata !== 2'd2) $display("FAIL upd_write_data: got %0d want 2", bus.mem_wdata); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL upd_busy: got %0b want 1", busy); else n_pass++;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.mem_en !== 1'b0 || busy !== 1'b0) $display("FAIL upd_after: got en=%0b busy=%0b want 0/0", bus.mem_en, busy); else n_pass++;
   endtask

   task automatic test_drop();
      cyc(0, 0, 1, 7, 3, 1, 0, 1, 0);
      n_checks++; if (bus.upd_ready !== 1'b1) $display("FAIL drop_ready: got %0b want 1", bus.upd_ready); else n_pass++;
      cyc(0, 0, 1, 7, 0, 0, 0, 1, 0);
      n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL drop_sat_hi: got en=%0b want 0", bus.mem_en); else n_pass++;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.mem_en !== 1'b0 || busy !== 1'b0) $display("FAIL drop_sat_lo: got en=%0b busy=%0b want 0/0", bus.mem_en, busy); else n_pass++;
   endtask

   task automatic test_bypass();
      cyc(1, 9, 1, 9, 0, 1, 0, 1, 0);
      cyc(1, 9, 1, 9, 1, 1, 0, 1, 0);
      n_checks++; if (bus.chooser_out !== 2'd3) $display("FAIL byp_first: got %0d want 3", bus.chooser_out); else n_pass++;
      cyc(1, 9, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.chooser_out !== W'(e_co)) $display("FAIL byp_one: got %0d want %0d", bus.chooser_out, e_co); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         cyc(1, 9, 0, 0, 0, 0, 0, 0, 0);
         n_checks++; if (bus.chooser_valid !== 1'b1 || bus.chooser_out !== 2'd2) $display("FAIL byp_young %0d: got v=%0b out=%0d want 1/2", i, bus.chooser_valid, bus.chooser_out); else n_pass++;
         n_checks++; if (bus.mem_we !== 1'b0) $display("FAIL byp_nowrite %0d: got %0b want 0", i, bus.mem_we); else n_pass++;
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 2'd1) $display("FAIL byp_drain1: got we=%0b d=%0d want 1/1", bus.mem_we, bus.mem_wdata); else n_pass++;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 2'd2) $display("FAIL byp_drain2: got we=%0b d=%0d want 1/2", bus.mem_we, bus.mem_wdata); else n_pass++;
      cyc(1, 9, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.chooser_out !== 2'd2) $display("FAIL byp_table: got %0d want 2", bus.chooser_out); else n_pass++;
   endtask

   task automatic test_full();
      for (int i = 1; i <= 4; i++) begin
         cyc(1, 0, 1, i, 0, 1, 0, 1, 0);
         n_checks++; if (bus.upd_ready !== 1'b1 || bus.mem_we !== 1'b0) $display("FAIL full_fill %0d: got rdy=%0b we=%0b want 1/0", i, bus.upd_ready, bus.mem_we); else n_pass++;
      end
      cyc(1, 0, 1, 6, 0, 1, 0, 1, 0);
      n_checks++; if (bus.pred_ready !== 1'b0 || bus.upd_ready !== 1'b0) $display("FAIL full_ready: got p=%0b u=%0b want 0/0", bus.pred_ready, bus.upd_ready); else n_pass++;
      n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 4'd1) $display("FAIL full_drain: got we=%0b a=%0d want 1/1", bus.mem_we, bus.mem_addr); else n_pass++;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.pred_ready !== 1'b1 || bus.mem_we !== 1'b0) $display("FAIL full_read: got p=%0b we=%0b want 1/0", bus.pred_ready, bus.mem_we); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
         n_checks++; if (bus.mem_en !== e_en || (e_en && bus.mem_addr !== IB'(e_addr))) $display("FAIL full_tail %0d: got en=%0b a=%0d want %0b/%0d", i, bus.mem_en, bus.mem_addr, e_en, e_addr); else n_pass++;
      end
   endtask

   task automatic test_flush();
      for (int i = 10; i < 13; i++) cyc(1, 0, 1, i, 0, 1, 0, 1, 0);
      cyc(0, 0, 1, 13, 0, 1, 0, 1, 1);
      n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 4'd10) $display("FAIL flush_inflight: got we=%0b a=%0d want 1/10", bus.mem_we, bus.mem_addr); else n_pass++;
      n_checks++; if (bus.chooser_valid !== 1'b1) $display("FAIL flush_cv: got %0b want 1", bus.chooser_valid); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
         n_checks++; if (bus.mem_en !== 1'b0 || busy !== 1'b0) $display("FAIL flush_empty %0d: got en=%0b busy=%0b want 0/0", i, bus.mem_en, busy); else n_pass++;
      end
   endtask

   task automatic test_random(input int n);
      bit pv, uv, fl;
      for (int i = 0; i < n; i++) begin
         pv = ($urandom_range(0, 99) < 55);
         uv = ($urandom_range(0, 99) < 70);
         fl = ($urandom_range(0, 99) < 3);
         cyc(pv, $urandom_range(0, 3), uv, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), 1'($urandom), fl);
         n_checks++; if (bus.mem_en !== e_en) $display("FAIL rnd_en %0d: got %0b want %0b", i, bus.mem_en, e_en); else n_pass++;
         if (e_en) begin
            n_checks++; if (bus.mem_we !== e_we || bus.mem_addr !== IB'(e_addr)) $display("FAIL rnd_port %0d: got we=%0b a=%0d want %0b/%0d", i, bus.mem_we, bus.mem_addr, e_we, e_addr); else n_pass++;
         end
         if (e_we) begin
            n_checks++; if (bus.mem_wdata !== W'(e_wdata)) $display("FAIL rnd_wdata %0d: got %0d want %0d", i, bus.mem_wdata, e_wdata); else n_pass++;
         end
         n_checks++; if (bus.pred_ready !== e_pr || bus.upd_ready !== e_ur) $display("FAIL rnd_ready %0d: got p=%0b u=%0b want %0b/%0b", i, bus.pred_ready, bus.upd_ready, e_pr, e_ur); else n_pass++;
         n_checks++; if (busy !== e_busy) $display("FAIL rnd_busy %0d: got %0b want %0b", i, busy, e_busy); else n_pass++;
         n_checks++; if (bus.chooser_valid !== e_cv) $display("FAIL rnd_cv %0d: got %0b want %0b", i, bus.chooser_valid, e_cv); else n_pass++;
         if (e_cv) begin
            n_checks++; if (bus.chooser_out !== W'(e_co)) $display("FAIL rnd_co %0d: got %0d want %0d", i, bus.chooser_out, e_co); else n_pass++;
         end
      end
   endtask

   task automatic test_midreset();
      cyc(1, 2, 1, 2, 0, 1, 0, 1, 0);
      cyc(1, 3, 1, 3, 0, 1, 0, 1, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b1 || bus.upd_ready !== 1'b0) $display("FAIL mid_rst: got busy=%0b u=%0b want 1/0", busy, bus.upd_ready); else n_pass++;
      n_checks++; if (bus.chooser_valid !== 1'b0 || bus.mem_en !== 1'b0) $display("FAIL mid_rst_port: got cv=%0b en=%0b want 0/0", bus.chooser_valid, bus.mem_en); else n_pass++;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 4'd0 || bus.mem_wdata !== 2'd3) $display("FAIL mid_sweep: got we=%0b a=%0d d=%0d want 1/0/3", bus.mem_we, bus.mem_addr, bus.mem_wdata); else n_pass++;
      test_random(60);
   endtask

   initial begin
      bus.pred_valid  = 1'b0;
      bus.pred_index  = '0;
      bus.upd_valid   = 1'b0;
      bus.upd_index   = '0;
      bus.upd_counter = '0;
      bus.upd_dir     = 1'b0;
      bus.upd_batage  = 1'b0;
      bus.upd_bfnp    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      test_reset();
      test_init();
      test_update_write();
      test_drop();
      test_bypass();
      test_full();
      test_flush();
      test_random(400);
      test_midreset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
